// File: rtl/uart_rx_core_if.sv
// Receiver-to-user-logic bundle: decoded byte, status pulses and line status.
// master = the receiver driving these signals, slave = the consuming logic.
// All signals are synchronous to the receiver clock.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] RX_DATA;
  logic                 RX_VALID;
  logic                 FRAME_ERR;
  logic                 PARITY_ERR;
  logic                 BUSY;
  logic                 ACTIVITY;

  modport master (
    output RX_DATA, RX_VALID, FRAME_ERR, PARITY_ERR, BUSY, ACTIVITY
  );

  modport slave (
    input RX_DATA, RX_VALID, FRAME_ERR, PARITY_ERR, BUSY, ACTIVITY
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, error pulses, activity stretcher.
// Latency: RX_VALID 2 + CLKS_PER_BIT/2 + (DATA_BITS + P + 1)*CLKS_PER_BIT clocks after the start edge.
// No backpressure: each byte is offered once with a one-cycle strobe. Parity via macro UART_RX_PARITY_EN.
module uart_rx_core #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int ACT_HOLD   = 50_000_000,
  parameter int PARITY_ODD = 0
) (
  input  logic           FPGA_CLK,
  input  logic           RST_N,
  input  logic           UART_RXD,
  uart_rx_core_if.master rx
);

  // CLKS_PER_BIT must be at least 4 so the half-bit start check is meaningful.
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int HOLD_W       = (ACT_HOLD > 1) ? $clog2(ACT_HOLD) : 1;

  localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_M1    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ACT_HOLD - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic              ODD_BIT   = (PARITY_ODD != 0);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  sh_q, sh_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  vld_q, vld_d;
  logic                  ferr_q, ferr_d;
  logic                  perr_q, perr_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  busy;
  logic                  rxd_s;
  logic                  stop_tick;
`ifdef UART_RX_PARITY_EN
  logic                  par_q, par_d;
`endif

  // Only the second synchroniser stage is ever looked at by the decoder.
  assign rxd_s     = sync_q[1];
  assign stop_tick = (state_q == S_STOP) && (cnt_q == BIT_M1);

  // State register, synchroniser and all output flops.
  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      hold_q  <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], UART_RXD};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      hold_q  <= hold_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state: bit timing, sampling at mid-bit and frame sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxd_s) state_d = S_START;
      end
      S_START: begin
        // A start bit that is high again at its mid-point was a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          sh_d  = {rxd_s, sh_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          par_d   = rxd_s;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Returning to IDLE at the stop mid-point lets a back-to-back start bit through.
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          state_d = rxd_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so a long break yields a single frame error.
        cnt_d = '0;
        if (rxd_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: byte/strobe/error pulses at the stop sample and the activity hold counter.
  always_comb begin
    data_d = data_q;
    vld_d  = 1'b0;
    ferr_d = 1'b0;
    perr_d = 1'b0;
    hold_d = (hold_q != '0) ? (hold_q - HOLD_W'(1)) : hold_q;
    if ((state_q == S_IDLE) && !rxd_s) hold_d = HOLD_LOAD;
    if (stop_tick) begin
      if (rxd_s) begin
        vld_d  = 1'b1;
        data_d = sh_q;
`ifdef UART_RX_PARITY_EN
        perr_d = par_q ^ (^sh_q) ^ ODD_BIT;
`endif
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign rx.RX_DATA    = data_q;
  assign rx.RX_VALID   = vld_q;
  assign rx.FRAME_ERR  = ferr_q;
  assign rx.PARITY_ERR = perr_q;
  assign rx.BUSY       = busy;
  assign rx.ACTIVITY   = (hold_q != '0) || busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 10 clocks per bit, 8 data bits, short activity hold.
// Inputs change on the falling clock edge; outputs are observed on the falling edge.
// Build with +define+UART_RX_PARITY_EN to add the parity frames.
module tb_uart_rx_core;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = 10;
  localparam int DB       = 8;
  localparam int ACT      = 20;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME_CLKS = (DB + P + 2) * CPB;
  localparam int LAT        = 2 + CPB / 2 + (DB + P + 1) * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;
`ifdef UART_RX_PARITY_EN
  logic par_force_en = 1'b0;
  logic par_force    = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_rx_core_if #(.DATA_BITS(DB)) rx ();

  uart_rx_core #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_BITS (DB),
    .ACT_HOLD  (ACT),
    .PARITY_ODD(0)
  ) dut (
    .FPGA_CLK(clk),
    .RST_N   (rst_n),
    .UART_RXD(rxd),
    .rx      (rx)
  );

  // Rising-edge count; a value of n at a falling edge means n rising edges have passed.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Running event log, sampled between rising edges.
  int vld_cnt = 0, ferr_cnt = 0, perr_cnt = 0, act_cnt = 0;
  int last_vld_cyc = 0, prev_vld_cyc = 0, last_act_cyc = 0;
  logic [DB-1:0] last_data = '0, prev_data = '0;
  logic last_perr = 1'b0;

  always @(negedge clk) begin
    if (rx.RX_VALID) begin
      vld_cnt      = vld_cnt + 1;
      prev_vld_cyc = last_vld_cyc;
      prev_data    = last_data;
      last_vld_cyc = cyc;
      last_data    = rx.RX_DATA;
      last_perr    = rx.PARITY_ERR;
    end
    if (rx.FRAME_ERR)  ferr_cnt = ferr_cnt + 1;
    if (rx.PARITY_ERR) perr_cnt = perr_cnt + 1;
    if (rx.ACTIVITY) begin
      act_cnt      = act_cnt + 1;
      last_act_cyc = cyc;
    end
  end

  int vecs = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vecs = vecs + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  // st = rising-edge index at which the pin is first seen low.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic idle_hi, output int st);
    st = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_force_en ? par_force : (^d));
`endif
    drive_bit(stop);
    rxd = idle_hi;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  int'(rx.RX_DATA),    0);
    check({tag, "_vld"},   int'(rx.RX_VALID),   0);
    check({tag, "_ferr"},  int'(rx.FRAME_ERR),  0);
    check({tag, "_perr"},  int'(rx.PARITY_ERR), 0);
    check({tag, "_busy"},  int'(rx.BUSY),       0);
    check({tag, "_act"},   int'(rx.ACTIVITY),   0);
  endtask

  typedef struct {
    logic [DB-1:0] d;
    logic          stop;
    int            exp_vld;
    int            exp_ferr;
    logic [DB-1:0] exp_data;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int st, st1, s_v, s_f, s_p, s_a, k;

    tbl[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    tbl[2] = '{8'h01, 1'b1, 1, 0, 8'h01};
    tbl[3] = '{8'h80, 1'b1, 1, 0, 8'h80};
    tbl[4] = '{8'h55, 1'b0, 0, 1, 8'h80};  // bad stop: byte dropped, data held
    tbl[5] = '{8'hFF, 1'b1, 1, 0, 8'hFF};

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("post_rst");

    // Table of single frames.
    for (int i = 0; i < 6; i++) begin
      s_v = vld_cnt; s_f = ferr_cnt; s_p = perr_cnt;
      send_frame(tbl[i].d, tbl[i].stop, 1'b1, st);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_vld", i),  vld_cnt - s_v,  tbl[i].exp_vld);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - s_f, tbl[i].exp_ferr);
      check($sformatf("vec%0d_perr", i), perr_cnt - s_p, 0);
      check($sformatf("vec%0d_data", i), int'(rx.RX_DATA), int'(tbl[i].exp_data));
      if (tbl[i].exp_vld != 0)
        check($sformatf("vec%0d_lat", i), last_vld_cyc - st, LAT);
      repeat (5) @(negedge clk);
    end

    // Back-to-back frames with no idle gap.
    s_v = vld_cnt;
    send_frame(8'h00, 1'b1, 1'b1, st1);
    send_frame(8'hFF, 1'b1, 1'b1, st);
    repeat (3) @(negedge clk);
    check("b2b_cnt",   vld_cnt - s_v, 2);
    check("b2b_lat1",  prev_vld_cyc - st1, LAT);
    check("b2b_gap",   last_vld_cyc - prev_vld_cyc, FRAME_CLKS);
    check("b2b_data1", int'(prev_data), 8'h00);
    check("b2b_data2", int'(last_data), 8'hFF);

    // 3-clock low glitch on an idle line.
    repeat (ACT + 5) @(negedge clk);
    s_v = vld_cnt; s_f = ferr_cnt; s_a = act_cnt;
    st = cyc + 1;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    k = 0;
    while (rx.BUSY && k < 20) begin
      @(negedge clk);
      k = k + 1;
    end
    check("glitch_busy_clks", k, 5);
    repeat (ACT + 10) @(negedge clk);
    check("glitch_vld",  vld_cnt - s_v, 0);
    check("glitch_ferr", ferr_cnt - s_f, 0);
    // Hold counter loads ACT-1 two clocks after the pin edge; last high cycle is ACT after it.
    check("glitch_act_clks", act_cnt - s_a, ACT - 1);
    check("glitch_act_end",  last_act_cyc - st, ACT);

    // Stop bit low, then line held low: one frame error, data held, idle after release.
    s_v = vld_cnt; s_f = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, st);
    repeat (300) @(negedge clk);
    check("brk_busy", int'(rx.BUSY), 1);
    check("brk_ferr", ferr_cnt - s_f, 1);
    check("brk_vld",  vld_cnt - s_v, 0);
    check("brk_data", int'(rx.RX_DATA), 8'hFF);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_idle", int'(rx.BUSY), 0);
    check("brk_ferr_once", ferr_cnt - s_f, 1);

    // Reset at data bit 4, then a clean frame.
    repeat (ACT + 5) @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    rst_n = 1'b0;
    rxd   = 1'b1;
    s_v = vld_cnt; s_f = ferr_cnt;
    repeat (2) @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("midrst_no_vld",  vld_cnt - s_v, 0);
    check("midrst_no_ferr", ferr_cnt - s_f, 0);
    send_frame(8'h5A, 1'b1, 1'b1, st);
    repeat (3) @(negedge clk);
    check("midrst_vld",  vld_cnt - s_v, 1);
    check("midrst_data", int'(rx.RX_DATA), 8'h5A);
    check("midrst_lat",  last_vld_cyc - st, LAT);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1.
    par_force_en = 1'b1;
    par_force    = 1'b1;
    s_v = vld_cnt; s_p = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1, st);
    repeat (3) @(negedge clk);
    check("par_ok_vld",  vld_cnt - s_v, 1);
    check("par_ok_perr", perr_cnt - s_p, 0);
    par_force = 1'b0;
    s_v = vld_cnt; s_p = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1, st);
    repeat (3) @(negedge clk);
    check("par_bad_vld",  vld_cnt - s_v, 1);
    check("par_bad_perr", perr_cnt - s_p, 1);
    check("par_bad_same", int'(last_perr), 1);
    check("par_bad_data", int'(rx.RX_DATA), 8'h07);
    par_force_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
